// File: rtl/branch_resolve_unit.sv
// Registered EX-stage branch resolver with a 2-bit saturating BHT and fetch lookup port.
// Optional BRU_STATS_EN adds saturating branch / mispredict counters.
module branch_resolve_unit #(
    parameter int         DATA_W    = 32,
    parameter int         PC_W      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] INIT_CTR  = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctrl,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_target,
    input  logic              in_pred_taken,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic              out_mispredict,
    output logic [PC_W-1:0]   out_redirect_pc,
    output logic              out_bad_ctrl,
`ifdef BRU_STATS_EN
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts,
`endif
    input  logic [PC_W-1:0]   lk_pc,
    output logic              lk_taken
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [3:0] BCU_EQ  = 4'h0;
    localparam logic [3:0] BCU_NE  = 4'h1;
    localparam logic [3:0] BCU_LT  = 4'h2;
    localparam logic [3:0] BCU_GE  = 4'h3;
    localparam logic [3:0] BCU_GT  = 4'h4;
    localparam logic [3:0] BCU_LE  = 4'h5;
    localparam logic [3:0] BCU_LTZ = 4'h6;
    localparam logic [3:0] BCU_GEZ = 4'h7;
    localparam logic [3:0] BCU_GTZ = 4'h8;
    localparam logic [3:0] BCU_LEZ = 4'h9;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]  r_init_idx;
    logic [1:0]        r_bht [BHT_DEPTH];

    logic              r_valid;
    logic              r_taken;
    logic              r_misp;
    logic [PC_W-1:0]   r_redir;
    logic              r_bad;

    logic              w_is_z;
    logic [DATA_W-1:0] w_b;
    logic              w_eq;
    logic              w_lt;
    logic              w_taken;
    logic              w_legal;
    logic              w_accept;
    logic              w_upd;
    logic [IDX_W-1:0]  w_upd_idx;
    logic [1:0]        w_ctr;
    logic [1:0]        w_ctr_nxt;
    logic              w_unused;

    assign w_unused = ^lk_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        unique case (r_state)
            S_INIT: begin
                if (r_init_idx == IDX_W'(BHT_DEPTH - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = !r_valid || out_ready;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_idx <= '0;
        end else if (r_state == S_INIT) begin
            r_init_idx <= r_init_idx + 1'b1;
        end
    end

    // Zero-compare codes reuse the two-operand comparator against a zero rhs
    assign w_is_z = (in_ctrl == BCU_LTZ) || (in_ctrl == BCU_GEZ) ||
                    (in_ctrl == BCU_GTZ) || (in_ctrl == BCU_LEZ);
    assign w_b    = w_is_z ? '0 : in_rd2;
    assign w_eq   = (in_rd1 == w_b);
    assign w_lt   = in_signed ? ($signed(in_rd1) < $signed(w_b))
                              : (in_rd1 < w_b);

    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        unique case (in_ctrl)
            BCU_EQ:           w_taken = w_eq;
            BCU_NE:           w_taken = !w_eq;
            BCU_LT, BCU_LTZ:  w_taken = w_lt;
            BCU_GE, BCU_GEZ:  w_taken = !w_lt;
            BCU_GT, BCU_GTZ:  w_taken = !w_lt && !w_eq;
            BCU_LE, BCU_LEZ:  w_taken = w_lt || w_eq;
            default:          w_legal = 1'b0;
        endcase
    end

    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_taken <= 1'b0;
            r_misp  <= 1'b0;
            r_redir <= '0;
            r_bad   <= 1'b0;
        end else if (flush && r_state == S_RUN) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_taken <= w_taken;
            r_misp  <= (w_taken != in_pred_taken);
            r_redir <= w_taken ? in_target : in_pc + PC_W'(4);
            r_bad   <= !w_legal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid       = r_valid;
    assign out_taken       = r_taken;
    assign out_mispredict  = r_misp;
    assign out_redirect_pc = r_redir;
    assign out_bad_ctrl    = r_bad;

    assign w_upd     = w_accept && w_legal;
    assign w_upd_idx = in_pc[IDX_W+1:2];
    assign w_ctr     = r_bht[w_upd_idx];

    always_comb begin
        w_ctr_nxt = w_ctr;
        if (w_taken && w_ctr != 2'b11) begin
            w_ctr_nxt = w_ctr + 2'b01;
        end else if (!w_taken && w_ctr != 2'b00) begin
            w_ctr_nxt = w_ctr - 2'b01;
        end
    end

    // Table storage carries no reset; the INIT sweep establishes its contents
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_bht[r_init_idx] <= INIT_CTR;
        end else if (w_upd) begin
            r_bht[w_upd_idx] <= w_ctr_nxt;
        end
    end

    assign lk_taken = r_bht[lk_pc[IDX_W+1:2]][1];

`ifdef BRU_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (w_upd) begin
            if (r_stat_br != '1) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (w_taken != in_pred_taken && r_stat_mp != '1) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;
`endif

endmodule
